// File: rtl/ethernet_perf_counter_reader.sv
// Snapshot, delta and clear engine for the MAC performance counters.
// Exposes shadows, deltas and status over a 32-bit management read port.
package eth_perf_pkg;
  typedef struct packed {
    logic [63:0] rx_frames;
    logic [63:0] rx_crc_err;
    logic [63:0] rx_bytes;
    logic [63:0] tx_frames;
    logic [63:0] tx_bytes;
  } EthernetMacPerformanceData;
endpackage

module ethernet_perf_counter_reader
  import eth_perf_pkg::*;
#(
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  EthernetMacPerformanceData counters,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd_op,
  output logic                      cmd_ready,
  input  logic                      rd_en,
  input  logic [4:0]                rd_addr,
  output logic                      rd_valid,
  output logic [31:0]               rd_data,
  output logic                      rst_rx_out,
  output logic                      rst_tx_out
);

  typedef enum logic [1:0] {
    IDLE,
    SNAP_CAPTURE,
    SNAP_DELTA,
    CLEARING
  } state_t;

  state_t      state;
  logic [63:0] live     [5];
  logic [63:0] shadow   [5];
  logic [63:0] baseline [5];
  logic [31:0] delta    [5];
  logic [31:0] delta_nx [5];
  logic [63:0] diff     [5];
  logic [15:0] snap_seq;
  logic [7:0]  clr_cnt;
  logic        clr_tx;
  logic        snap_busy;
  logic [31:0] rd_word;
  logic [2:0]  sidx;
  logic [2:0]  didx;

  assign live[0] = counters.rx_frames;
  assign live[1] = counters.rx_crc_err;
  assign live[2] = counters.rx_bytes;
  assign live[3] = counters.tx_frames;
  assign live[4] = counters.tx_bytes;

  assign snap_busy = (state == SNAP_CAPTURE) ||
                     (state == SNAP_DELTA);

  // Per-counter delta; a shrinking counter means it was cleared externally.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      if (shadow[i] < baseline[i])
        diff[i] = shadow[i];
      else
        diff[i] = shadow[i] - baseline[i];
      delta_nx[i] = (|diff[i][63:32]) ? 32'hFFFF_FFFF
                                      : diff[i][31:0];
    end
  end

  // Command FSM: snapshot, delta computation and timed clear pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      rst_rx_out <= 1'b0;
      rst_tx_out <= 1'b0;
      clr_cnt    <= '0;
      clr_tx     <= 1'b0;
      snap_seq   <= '0;
      for (int i = 0; i < 5; i++) begin
        shadow[i]   <= '0;
        baseline[i] <= '0;
        delta[i]    <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_op == 2'd1) begin
              state     <= SNAP_CAPTURE;
              cmd_ready <= 1'b0;
            end else if (cmd_op != 2'd0) begin
              state      <= CLEARING;
              cmd_ready  <= 1'b0;
              clr_tx     <= (cmd_op == 2'd3);
              rst_rx_out <= (cmd_op == 2'd2);
              rst_tx_out <= (cmd_op == 2'd3);
              clr_cnt    <= 8'(CLEAR_CYCLES - 1);
            end
          end
        end
        SNAP_CAPTURE: begin
          for (int i = 0; i < 5; i++) begin
            shadow[i]   <= live[i];
            baseline[i] <= shadow[i];
          end
          state <= SNAP_DELTA;
        end
        SNAP_DELTA: begin
          for (int i = 0; i < 5; i++)
            delta[i] <= delta_nx[i];
          snap_seq  <= snap_seq + 16'd1;
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        CLEARING: begin
          if (clr_cnt == 8'd0) begin
            for (int i = 0; i < 5; i++)
              if ((i >= 3) == clr_tx)
                shadow[i] <= '0;
            rst_rx_out <= 1'b0;
            rst_tx_out <= 1'b0;
            state      <= IDLE;
            cmd_ready  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sidx = rd_addr[3:1];
  assign didx = 3'(rd_addr - 5'd10);

  // Address decode of the management-visible register file.
  always_comb begin
    rd_word = '0;
    if (rd_addr < 5'd10)
      rd_word = rd_addr[0] ? shadow[sidx][63:32]
                           : shadow[sidx][31:0];
    else if (rd_addr < 5'd15)
      rd_word = delta[didx];
    else if (rd_addr == 5'd15)
      rd_word = {snap_seq, 13'b0, rst_tx_out,
                 rst_rx_out, snap_busy};
  end

  // One-cycle read pipeline; data holds when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_ethernet_perf_counter_reader.sv
// Randomized bench for ethernet_perf_counter_reader.
// Expected values come from an array model of the register file.
module tb_ethernet_perf_counter_reader;
  import eth_perf_pkg::*;

  localparam int CC = 4;

  logic clk = 1'b0;
  logic rst;
  EthernetMacPerformanceData counters;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rst_rx_out;
  logic        rst_tx_out;

  int total = 0;
  int bad   = 0;

  logic [63:0] cnt_m  [5];
  logic [63:0] sh_m   [5];
  logic [63:0] base_m [5];
  logic [31:0] dl_m   [5];
  logic [15:0] seq_m;

  always #5 clk = ~clk;

  assign counters = '{rx_frames:  cnt_m[0],
                      rx_crc_err: cnt_m[1],
                      rx_bytes:   cnt_m[2],
                      tx_frames:  cnt_m[3],
                      tx_bytes:   cnt_m[4]};

  ethernet_perf_counter_reader #(.CLEAR_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .counters(counters),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rst_rx_out(rst_rx_out),
    .rst_tx_out(rst_tx_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      sh_m[i] = '0; base_m[i] = '0; dl_m[i] = '0;
    end
    seq_m = '0;
  endtask

  function automatic logic [31:0] exp_rd(input int a);
    logic [63:0] w;
    if (a < 10) begin
      w = sh_m[a / 2];
      return (a % 2 == 1) ? w[63:32] : w[31:0];
    end
    if (a < 15) return dl_m[a - 10];
    if (a == 15) return {seq_m, 16'h0};
    return 32'h0;
  endfunction

  task automatic readback(input string tag);
    for (int a = 0; a <= 32; a++) begin
      @(negedge clk);
      if (a > 0) begin
        chk({tag, "_vld"}, 64'(rd_valid), 64'd1);
        chk($sformatf("%s_a%0d", tag, a - 1),
            64'(rd_data), 64'(exp_rd(a - 1)));
      end
      if (a < 32) begin
        rd_en = 1'b1; rd_addr = 5'(a);
      end else begin
        rd_en = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_idle_vld"}, 64'(rd_valid), 64'd0);
    chk({tag, "_hold"}, 64'(rd_data), 64'(exp_rd(31)));
  endtask

  task automatic read1(input int a, input logic [31:0] exp,
                       input string tag);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 5'(a);
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_vld"}, 64'(rd_valid), 64'd1);
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic snapshot();
    logic [63:0] d;
    @(negedge clk);
    chk("snap_rdy_pre", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("snap_rdy_c1", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("snap_rdy_c2", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("snap_rdy_c3", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      base_m[i] = sh_m[i];
      sh_m[i]   = cnt_m[i];
      d = (sh_m[i] < base_m[i]) ? sh_m[i]
                                : sh_m[i] - base_m[i];
      dl_m[i] = (d > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
    end
    seq_m = seq_m + 16'd1;
  endtask

  task automatic clear(input bit tx);
    int  n;
    bit  other;
    logic tgt;
    n = 0; other = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = tx ? 2'd3 : 2'd2;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      cmd_op = 2'd1;
      tgt = tx ? rst_tx_out : rst_rx_out;
      if ((tx ? rst_rx_out : rst_tx_out) !== 1'b0) other = 1;
      if (tgt === 1'b1) n++;
      else break;
    end
    cmd_valid = 1'b0;
    chk(tx ? "clr_tx_len" : "clr_rx_len", 64'(n), 64'(CC));
    chk(tx ? "clr_tx_oth" : "clr_rx_oth", 64'(other), 64'd0);
    chk("clr_rdy_end", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 5; i++)
      if ((i >= 3) == tx) sh_m[i] = '0;
  endtask

  initial begin
    int op;
    int r;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0;
    rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < 5; i++) cnt_m[i] = '0;
    model_reset();
    #12;
    chk("rst_rdy", 64'(cmd_ready), 64'd1);
    chk("rst_vld", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_rxo", 64'(rst_rx_out), 64'd0);
    chk("rst_txo", 64'(rst_tx_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    read1(15, 32'h0, "rst_status");

    cnt_m[2] = 64'h0000_0001_2345_6789;
    snapshot();
    read1(4, 32'h2345_6789, "rxb_lo");
    read1(5, 32'h0000_0001, "rxb_hi");
    read1(12, 32'hFFFF_FFFF, "rxb_sat");
    read1(15, 32'h0001_0000, "status1");
    readback("snap1");

    cnt_m[0] = 64'd100;
    snapshot();
    cnt_m[0] = 64'd250;
    snapshot();
    read1(10, 32'd150, "rxf_delta");
    readback("snap3");

    cnt_m[3] = 64'h1234; cnt_m[4] = 64'h5678_9ABC_DEF0;
    snapshot();
    clear(1'b0);
    readback("clr_rx");

    force dut.snap_seq = 16'hFFFF;
    @(negedge clk);
    release dut.snap_seq;
    seq_m = 16'hFFFF;
    snapshot();
    read1(15, 32'h0000_0000, "seq_wrap");

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 5; i++) begin
        r = $urandom_range(0, 9);
        if (r <= 5) cnt_m[i] += 64'($urandom_range(0, 1000));
        else if (r == 6) cnt_m[i] += 64'($urandom) << 20;
        else if (r == 7) cnt_m[i] = 64'($urandom_range(0, 50));
      end
      op = $urandom_range(0, 3);
      if (op == 0) begin
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("nop_rdy", 64'(cmd_ready), 64'd1);
      end else if (op == 1) begin
        snapshot();
      end else begin
        clear(op == 3);
      end
      readback($sformatf("rnd%0d", it));
    end

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rxo_hi", 64'(rst_rx_out), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rxo", 64'(rst_rx_out), 64'd0);
    chk("mid_rdy", 64'(cmd_ready), 64'd1);
    chk("mid_vld", 64'(rd_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    readback("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
